wave_streamer: RTL and testbench

WAVE_STREAMER -- requirements
Module: wave_streamer

---
 rtl/wave_streamer.sv | 241 ++++++++++++++++++++++++
 tb/tb_wave_streamer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_streamer.sv
// Streams one waveform frame (header, NCH*DEPTH samples, checksum trailer) from a
// synchronous waveform RAM, prefetching through a 2-entry skid buffer.
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high; out_valid never looks at out_ready, and a presented
// word (out_data/out_last) holds until it transfers.
module wave_streamer #(
  parameter int SAMPLE_W = 14,
  parameter int DEPTH    = 1000,
  parameter int NCH      = 1,
  parameter int OUT_W    = 16,
  parameter int SIGNED   = 0,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CHW     = $clog2((NCH > 2) ? NCH : 2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         wavenum,
  output logic                busy,
  output logic [CHW-1:0]      rd_ch,
  output logic [AW-1:0]       rd_addr,
  output logic                rd_en,
  input  logic [SAMPLE_W-1:0] rd_data,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [15:0]         lastwavenum,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_SAMP = 2'd2;
  localparam logic [1:0] S_TRL  = 2'd3;

  localparam int TOTAL = NCH * DEPTH;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CHW-1:0] LAST_CH   = CHW'(NCH - 1);
  localparam logic [CW-1:0]  LAST_SAMP = CW'(TOTAL - 1);

  logic [1:0]       state_q, state_d;
  logic [15:0]      wav_q, wav_d;
  logic [15:0]      last_wav_q, last_wav_d;
  logic [15:0]      csum_q, csum_d;
  logic [CW-1:0]    pcnt_q, pcnt_d;

  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [CHW-1:0]   rd_ch_q, rd_ch_d;
  logic [AW-1:0]    nxt_addr_q, nxt_addr_d;
  logic [CHW-1:0]   nxt_ch_q, nxt_ch_d;
  logic             rd_done_q, rd_done_d;
  logic             infl_q;

  logic [OUT_W-1:0] buf_q [2];
  logic             wptr_q, rptr_q;
  logic [1:0]       cnt_q, cnt_d;

  logic [OUT_W-1:0] ext_data;
  logic [OUT_W-1:0] samp_word;
  logic             samp_avail;
  logic             valid_c;
  logic [OUT_W-1:0] data_c;
  logic             hs;
  logic             pop;
  logic             push;
  logic             buf_pop;
  logic             can_prefetch;
  logic [2:0]       occ;
  logic             issue;

  function automatic logic [OUT_W-1:0] extend(input logic [SAMPLE_W-1:0] s);
    logic [OUT_W-1:0] r;
    r = '0;
    r[SAMPLE_W-1:0] = s;
    if (SIGNED != 0) begin
      for (int i = SAMPLE_W; i < OUT_W; i++) r[i] = s[SAMPLE_W-1];
    end
    return r;
  endfunction

  assign ext_data = extend(rd_data);

  // Head sample is the oldest buffered entry, or the RAM return itself when the
  // buffer is empty, which keeps the stream at one word per cycle.
  assign samp_avail = (cnt_q != 2'd0) || infl_q;
  assign samp_word  = (cnt_q != 2'd0) ? buf_q[rptr_q] : ext_data;

  always_comb begin
    valid_c = 1'b0;
    data_c  = '0;
    case (state_q)
      S_HDR: begin
        valid_c = 1'b1;
        data_c  = OUT_W'(wav_q);
      end
      S_SAMP: begin
        valid_c = samp_avail;
        data_c  = samp_word;
      end
      S_TRL: begin
        valid_c = 1'b1;
        data_c  = OUT_W'(csum_q);
      end
      default: begin
        valid_c = 1'b0;
        data_c  = '0;
      end
    endcase
  end

  assign hs      = valid_c && out_ready;
  assign pop     = (state_q == S_SAMP) && hs;
  assign push    = infl_q && !(pop && (cnt_q == 2'd0));
  assign buf_pop = pop && (cnt_q != 2'd0);

  // A read may issue only if buffered + in-flight + current read, after this
  // cycle's pop, leaves room for one more entry.
  assign can_prefetch = ((state_q == S_IDLE) && start) ||
                        (((state_q == S_HDR) || (state_q == S_SAMP)) && !rd_done_q);
  assign occ   = {1'b0, cnt_q} + {2'b00, infl_q} + {2'b00, rd_en_q} - {2'b00, pop};
  assign issue = can_prefetch && (occ <= 3'd1);

  always_comb begin
    state_d    = state_q;
    wav_d      = wav_q;
    last_wav_d = last_wav_q;
    csum_d     = csum_q;
    pcnt_d     = pcnt_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_ch_d    = rd_ch_q;
    nxt_addr_d = nxt_addr_q;
    nxt_ch_d   = nxt_ch_q;
    rd_done_d  = rd_done_q;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, buf_pop};

    if (issue) begin
      rd_en_d   = 1'b1;
      rd_addr_d = nxt_addr_q;
      rd_ch_d   = nxt_ch_q;
      if (nxt_addr_q == LAST_ADDR) begin
        nxt_addr_d = '0;
        if (nxt_ch_q == LAST_CH) rd_done_d = 1'b1;
        else nxt_ch_d = nxt_ch_q + CHW'(1);
      end else begin
        nxt_addr_d = nxt_addr_q + AW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wav_d   = wavenum;
          csum_d  = '0;
          pcnt_d  = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (hs) state_d = S_SAMP;
      end
      S_SAMP: begin
        if (pop) begin
          csum_d = csum_q + 16'(samp_word);
          pcnt_d = pcnt_q + CW'(1);
          if (pcnt_q == LAST_SAMP) begin
            pcnt_d  = '0;
            state_d = S_TRL;
          end
        end
      end
      S_TRL: begin
        if (hs) begin
          last_wav_d = wav_q;
          nxt_addr_d = '0;
          nxt_ch_d   = '0;
          rd_done_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wav_q      <= '0;
      last_wav_q <= 16'hFFFF;
      csum_q     <= '0;
      pcnt_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_ch_q    <= '0;
      nxt_addr_q <= '0;
      nxt_ch_q   <= '0;
      rd_done_q  <= 1'b0;
      infl_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      wav_q      <= wav_d;
      last_wav_q <= last_wav_d;
      csum_q     <= csum_d;
      pcnt_q     <= pcnt_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_ch_q    <= rd_ch_d;
      nxt_addr_q <= nxt_addr_d;
      nxt_ch_q   <= nxt_ch_d;
      rd_done_q  <= rd_done_d;
      infl_q     <= rd_en_q;
      cnt_q      <= cnt_d;
      if (push) begin
        buf_q[wptr_q] <= ext_data;
        wptr_q        <= ~wptr_q;
      end
      if (buf_pop) rptr_q <= ~rptr_q;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign rd_ch       = rd_ch_q;
  assign out_valid   = valid_c;
  assign out_data    = data_c;
  assign out_last    = (state_q == S_TRL);
  assign lastwavenum = last_wav_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_wave_streamer.sv
// Bench for wave_streamer: unsigned and signed instances share stimulus; a frame
// model built from the RAM contents feeds per-instance expected queues.
module tb_wave_streamer;
  localparam int SW    = 14;
  localparam int OW    = 16;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int TOTAL = NCH * DEPTH;
  localparam int AW    = 2;
  localparam int CHW   = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   wavenum;
  logic          out_ready;

  logic          busy_u, rd_en_u, out_valid_u, out_last_u;
  logic [CHW-1:0] rd_ch_u;
  logic [AW-1:0] rd_addr_u;
  logic [SW-1:0] rd_data_u;
  logic [OW-1:0] out_data_u;
  logic [15:0]   lastwav_u;
  logic [1:0]    dbg_u;

  logic          busy_s, rd_en_s, out_valid_s, out_last_s;
  logic [CHW-1:0] rd_ch_s;
  logic [AW-1:0] rd_addr_s;
  logic [SW-1:0] rd_data_s;
  logic [OW-1:0] out_data_s;
  logic [15:0]   lastwav_s;
  logic [1:0]    dbg_s;

  logic [SW-1:0] mem [NCH][DEPTH];
  logic [OW-1:0] exp_u[$];
  logic [OW-1:0] exp_s[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mode = 0;
  int widx_u = 0, widx_s = 0, rd_idx = 0;
  int first_hs = 0, last_hs = 0;
  logic [OW-1:0] s0_u, s0_s;
  logic          stall_q = 1'b0;
  logic [OW-1:0] hold_data;
  logic          hold_last;

  wave_streamer #(.SAMPLE_W(SW), .DEPTH(DEPTH), .NCH(NCH), .OUT_W(OW), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .start(start), .wavenum(wavenum), .busy(busy_u),
    .rd_ch(rd_ch_u), .rd_addr(rd_addr_u), .rd_en(rd_en_u), .rd_data(rd_data_u),
    .out_data(out_data_u), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_last(out_last_u), .lastwavenum(lastwav_u), .dbg_state(dbg_u)
  );

  wave_streamer #(.SAMPLE_W(SW), .DEPTH(DEPTH), .NCH(NCH), .OUT_W(OW), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .wavenum(wavenum), .busy(busy_s),
    .rd_ch(rd_ch_s), .rd_addr(rd_addr_s), .rd_en(rd_en_s), .rd_data(rd_data_s),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_last(out_last_s), .lastwavenum(lastwav_s), .dbg_state(dbg_s)
  );

  // Clock and cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: one-cycle read latency, garbage on idle cycles
  always @(posedge clk) begin
    if (rd_en_u) rd_data_u <= mem[rd_ch_u][rd_addr_u];
    else rd_data_u <= SW'($urandom);
    if (rd_en_s) rd_data_s <= mem[rd_ch_s][rd_addr_s];
    else rd_data_s <= SW'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame model: header, samples in channel-major order, 16-bit sum trailer
  task automatic build_exp(input logic [15:0] wav);
    logic [15:0]   sum_u, sum_s;
    logic [OW-1:0] e_u, e_s;
    sum_u = '0;
    sum_s = '0;
    exp_u.push_back(wav);
    exp_s.push_back(wav);
    for (int c = 0; c < NCH; c++) begin
      for (int a = 0; a < DEPTH; a++) begin
        e_u = OW'(mem[c][a]);
        e_s = OW'($signed(mem[c][a]));
        exp_u.push_back(e_u);
        exp_s.push_back(e_s);
        sum_u = sum_u + e_u;
        sum_s = sum_s + e_s;
      end
    end
    exp_u.push_back(sum_u);
    exp_s.push_back(sum_s);
    rd_idx = 0;
    widx_u = 0;
    widx_s = 0;
  endtask

  task automatic fill_random();
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < DEPTH; a++) mem[c][a] = SW'($urandom);
  endtask

  task automatic run_frame(input logic [15:0] wav);
    @(posedge clk); #1;
    build_exp(wav);
    start = 1'b1;
    wavenum = wav;
    @(posedge clk); #1;
    start = 1'b0;
    wavenum = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_u.size() != 0 || exp_s.size() != 0 || busy_u || busy_s) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_done", 32'(exp_u.size() == 0 && exp_s.size() == 0 && !busy_u && !busy_s), 1);
  endtask

  // out_ready driver
  initial begin
    int k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    logic [OW-1:0] w;
    int consumed;
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 32'(out_valid_u), 1);
        chk("hold_data", 32'(out_data_u), 32'(hold_data));
        chk("hold_last", 32'(out_last_u), 32'(hold_last));
      end
      stall_q   = out_valid_u && !out_ready;
      hold_data = out_data_u;
      hold_last = out_last_u;
      if (rd_en_u) begin
        chk("rd_range", 32'(rd_idx < TOTAL), 1);
        chk("rd_ch", 32'(rd_ch_u), 32'(rd_idx / DEPTH));
        chk("rd_addr", 32'(rd_addr_u), 32'(rd_idx % DEPTH));
        rd_idx++;
        consumed = (widx_u == 0) ? 0 : (((widx_u - 1) > TOTAL) ? TOTAL : widx_u - 1);
        chk("rd_credit", 32'((rd_idx - consumed) <= 2), 1);
      end
      if (out_valid_u && out_ready) begin
        if (exp_u.size() == 0) chk("extra_u", 32'(out_valid_u), 0);
        else begin
          w = exp_u.pop_front();
          chk("word_u", 32'(out_data_u), 32'(w));
          chk("last_u", 32'(out_last_u), 32'(exp_u.size() == 0));
          if (widx_u == 0) first_hs = cyc;
          if (widx_u == 1) s0_u = out_data_u;
          widx_u++;
          if (exp_u.size() == 0) begin
            last_hs = cyc;
            widx_u = 0;
          end
        end
      end
      if (out_valid_s && out_ready) begin
        if (exp_s.size() == 0) chk("extra_s", 32'(out_valid_s), 0);
        else begin
          w = exp_s.pop_front();
          chk("word_s", 32'(out_data_s), 32'(w));
          chk("last_s", 32'(out_last_s), 32'(exp_s.size() == 0));
          if (widx_s == 1) s0_s = out_data_s;
          widx_s++;
          if (exp_s.size() == 0) widx_s = 0;
        end
      end
    end
  end

  initial begin
    int n;
    logic [15:0] wv;
    reset = 1'b1;
    start = 1'b0;
    wavenum = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_u), 0);
    chk("rst_valid", 32'(out_valid_u), 0);
    chk("rst_last", 32'(out_last_u), 0);
    chk("rst_rd_en", 32'(rd_en_u), 0);
    chk("rst_rd_addr", 32'(rd_addr_u), 0);
    chk("rst_rd_ch", 32'(rd_ch_u), 0);
    chk("rst_data", 32'(out_data_u), 0);
    chk("rst_lastwav", 32'(lastwav_u), 32'hFFFF);
    chk("rst_state", 32'(dbg_u), 0);
    reset = 1'b0;

    // Basic frame at full rate
    for (int a = 0; a < DEPTH; a++) begin
      mem[0][a] = SW'(a + 1);
      mem[1][a] = SW'(a + 5);
    end
    mode = 0;
    run_frame(16'd7);
    wait_done(100);
    chk("consec_cycles", 32'(last_hs - first_hs), 9);
    chk("lastwav_basic_u", 32'(lastwav_u), 7);
    chk("lastwav_basic_s", 32'(lastwav_s), 7);

    // Same frame under 1,0,0,1 backpressure
    mode = 1;
    run_frame(16'd7);
    wait_done(200);

    // Sign extension of the most negative 14-bit sample
    fill_random();
    mem[0][0] = 14'h2000;
    mode = 0;
    run_frame(16'h0042);
    wait_done(100);
    chk("ext_unsigned", 32'(s0_u), 32'h2000);
    chk("ext_signed", 32'(s0_s), 32'hE000);

    // Reset after the third handshake aborts the frame
    fill_random();
    mode = 0;
    run_frame(16'h0033);
    n = 0;
    while (widx_u < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_third", 32'(widx_u), 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_u.delete();
    exp_s.delete();
    widx_u = 0;
    widx_s = 0;
    chk("abort_busy", 32'(busy_u), 0);
    chk("abort_valid", 32'(out_valid_u), 0);
    chk("abort_lastwav", 32'(lastwav_u), 32'hFFFF);
    mode = 2;
    run_frame(16'd9);
    wait_done(300);
    chk("after_abort_lastwav", 32'(lastwav_u), 9);

    // Start pulses while busy are ignored
    fill_random();
    mode = 2;
    run_frame(16'h1234);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (busy_u) begin
        start = 1'b1;
        wavenum = 16'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    wait_done(300);
    repeat (10) @(posedge clk);
    #1;
    chk("single_frame_busy", 32'(busy_u), 0);
    chk("lastwav_noise", 32'(lastwav_u), 32'h1234);

    // Back-to-back: start on the trailer handshake is ignored, next cycle accepted
    fill_random();
    mode = 2;
    run_frame(16'hA001);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid_u && out_ready && out_last_u) && n < 300);
    chk("b2b_trailer_seen", 32'(out_valid_u && out_ready && out_last_u), 1);
    start = 1'b1;
    wavenum = 16'hBAD0;
    @(posedge clk); #1;
    build_exp(16'hA002);
    wavenum = 16'hA002;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy_u), 1);
    wait_done(300);
    chk("b2b_lastwav", 32'(lastwav_u), 32'hA002);

    // Random frames under random ready patterns
    for (int f = 0; f < 6; f++) begin
      fill_random();
      mode = $urandom_range(0, 2);
      wv = 16'($urandom);
      run_frame(wv);
      wait_done(300);
      chk("rand_lastwav_u", 32'(lastwav_u), 32'(wv));
      chk("rand_lastwav_s", 32'(lastwav_s), 32'(wv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
